// File: rtl/ta_stream_accum_pkg.sv
// ----------------------------------------------------------------------------
// ta_pkg
// Shared types and helpers for the truncation-adder stream accumulator.
//   ta_state_e   : FSM state encoding (IDLE, ACCUM, HOLD)
//   border_mask  : all-ones mask with bits [b-1:0] cleared (callers slice it
//                  down to their accumulator width, up to 64 bits)
// ----------------------------------------------------------------------------
package ta_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } ta_state_e;

   function automatic logic [63:0] border_mask(input logic [7:0] b);
      return {64{1'b1}} << b;
   endfunction

endpackage

// File: rtl/ta_stream_accum_if.sv
// ----------------------------------------------------------------------------
// ta_stream_accum_if
// Operand/result stream bundle for ta_stream_accum.
//   cfg_border / cfg_len : per-group configuration, sampled on the first beat
//   in_valid / in_ready / in_a            : operand stream
//   out_valid / out_ready / out_sum / out_ovf : result stream
// Modports: slave = accumulator side, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface ta_stream_accum_if #(
   parameter int BITWIDTH   = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int MAX_BORDER = 4,
   parameter int LEN_WIDTH  = 8
);
   localparam int BW = $clog2(MAX_BORDER + 1);

   logic [BW-1:0]        cfg_border;
   logic [LEN_WIDTH-1:0] cfg_len;
   logic                 in_valid;
   logic                 in_ready;
   logic [BITWIDTH-1:0]  in_a;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_sum;
   logic                 out_ovf;

   modport slave (
      input  cfg_border, cfg_len, in_valid, in_a, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );

   modport master (
      output cfg_border, cfg_len, in_valid, in_a, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/ta_stream_accum_adder.sv
// ----------------------------------------------------------------------------
// ta_stream_accum_adder
// Unsigned BITWIDTH-bit adder with carry-in, result carries the carry-out in
// o_sum[BITWIDTH].
//   SUBTYPE 0 : ripple-carry
//   SUBTYPE 1 : carry-lookahead (each carry flattened from generate/propagate)
// Ports: i_a, i_b (BITWIDTH), i_cin, o_sum (BITWIDTH+1)
// ----------------------------------------------------------------------------
module ta_stream_accum_adder #(
   parameter int BITWIDTH = 16,
   parameter int SUBTYPE  = 1
) (
   input  logic [BITWIDTH-1:0] i_a,
   input  logic [BITWIDTH-1:0] i_b,
   input  logic                i_cin,
   output logic [BITWIDTH:0]   o_sum
);
   logic [BITWIDTH-1:0] w_g;
   logic [BITWIDTH-1:0] w_p;
   logic [BITWIDTH:0]   w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   if (SUBTYPE == 0) begin : g_rca
      assign w_c[0] = i_cin;
      for (genvar i = 0; i < BITWIDTH; i++) begin : g_bit
         assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
   end else begin : g_cla
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit
      always_comb begin
         logic t_c;
         logic t_p;
         w_c    = '0;
         w_c[0] = i_cin;
         for (int i = 0; i < BITWIDTH; i++) begin
            t_c = w_g[i];
            t_p = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
               t_c = t_c | (t_p & w_g[j]);
               t_p = t_p & w_p[j];
            end
            w_c[i+1] = t_c | (t_p & i_cin);
         end
      end
   end

   assign o_sum = {w_c[BITWIDTH], w_p ^ w_c[BITWIDTH-1:0]};
endmodule

// File: rtl/ta_stream_accum.sv
// ----------------------------------------------------------------------------
// ta_stream_accum
// Streaming truncation-adder accumulator: sums cfg_len operands per group,
// clearing the low cfg_border bits of each addend, saturating on overflow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ta_stream_accum_if.slave (cfg, operand stream, result stream)
// Build option:
//   TA_ROUND_COMP_EN : add in_a[b-1] << b to each truncated addend
//                      (round-half-up compensation); absent = plain truncation
// ----------------------------------------------------------------------------
module ta_stream_accum
   import ta_pkg::*;
#(
   parameter int BITWIDTH   = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int MAX_BORDER = 4,
   parameter int LEN_WIDTH  = 8,
   parameter int SUBTYPE    = 1
) (
   input logic              clk,
   input logic              rst_n,
   ta_stream_accum_if.slave bus
);
   localparam int BW = $clog2(MAX_BORDER + 1);

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
   localparam logic [1:0] ST_HOLD  = 2'(HOLD);

   logic [1:0]           r_state;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic [LEN_WIDTH-1:0] r_len;
   logic [BW-1:0]        r_border;
   logic [ACC_WIDTH-1:0] r_sum;
   logic                 r_sum_ovf;

   logic                 w_in_ready;
   logic                 w_fire;
   logic                 w_start;
   logic [BW-1:0]        w_b_cfg;
   logic [LEN_WIDTH-1:0] w_len_cfg;
   logic [BW-1:0]        w_b;
   logic [BITWIDTH-1:0]  w_a;
   logic [ACC_WIDTH-1:0] w_ext;
   logic [ACC_WIDTH-1:0] w_mask;
   logic [ACC_WIDTH-1:0] w_addend;
   logic [ACC_WIDTH-1:0] w_add_a;
   logic [ACC_WIDTH:0]   w_sum;
   logic [ACC_WIDTH-1:0] w_acc_nxt;
   logic                 w_ovf_nxt;
   logic [LEN_WIDTH-1:0] w_cnt_nxt;
   logic [LEN_WIDTH-1:0] w_len_cur;
   logic                 w_last;

   // HOLD only accepts a new first beat when the result leaves the same cycle
   assign w_in_ready = (r_state == ST_HOLD) ? bus.out_ready : 1'b1;
   assign w_fire     = bus.in_valid && w_in_ready;
   assign w_start    = w_fire && (r_state != ST_ACCUM);

   assign w_b_cfg   = (bus.cfg_border > BW'(MAX_BORDER)) ? BW'(MAX_BORDER) : bus.cfg_border;
   assign w_len_cfg = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;

   // first beat uses the live config, later beats the latched copy
   assign w_b       = w_start ? w_b_cfg : r_border;
   assign w_len_cur = w_start ? w_len_cfg : r_len;

   assign w_a    = bus.in_a;
   assign w_ext  = ACC_WIDTH'(w_a);
   assign w_mask = ACC_WIDTH'(border_mask(8'(w_b)));

`ifdef TA_ROUND_COMP_EN
   logic w_rbit;
   assign w_rbit   = (w_b != '0) && w_ext[w_b - 1'b1];
   assign w_addend = (w_ext & w_mask) + (ACC_WIDTH'(w_rbit) << w_b);
`else
   assign w_addend = w_ext & w_mask;
`endif

   // a first beat loads the addend alone, so the adder sees zero
   assign w_add_a = w_start ? '0 : r_acc;

   ta_stream_accum_adder #(
      .BITWIDTH (ACC_WIDTH),
      .SUBTYPE  (SUBTYPE)
   ) u_adder (
      .i_a   (w_add_a),
      .i_b   (w_addend),
      .i_cin (1'b0),
      .o_sum (w_sum)
   );

   assign w_acc_nxt = w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
   assign w_ovf_nxt = w_sum[ACC_WIDTH] | (~w_start & r_ovf);
   assign w_cnt_nxt = w_start ? LEN_WIDTH'(1) : r_cnt + 1'b1;
   assign w_last    = (w_cnt_nxt == w_len_cur);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
         r_len     <= '0;
         r_border  <= '0;
         r_sum     <= '0;
         r_sum_ovf <= 1'b0;
      end else if (w_fire) begin
         r_acc <= w_acc_nxt;
         r_ovf <= w_ovf_nxt;
         r_cnt <= w_cnt_nxt;
         if (w_start) begin
            r_border <= w_b_cfg;
            r_len    <= w_len_cfg;
         end
         if (w_last) begin
            r_state   <= ST_HOLD;
            r_sum     <= w_acc_nxt;
            r_sum_ovf <= w_ovf_nxt;
         end else begin
            r_state <= ST_ACCUM;
         end
      end else if (r_state == ST_HOLD && bus.out_ready) begin
         r_state <= ST_IDLE;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.out_sum   = r_sum;
   assign bus.out_ovf   = r_sum_ovf;
endmodule

// File: tb/tb_ta_stream_accum.sv
// ----------------------------------------------------------------------------
// tb_ta_stream_accum
// Directed vectors against two accumulator instances (ACC_WIDTH 16 / CLA and
// ACC_WIDTH 10 / RCA). Expected results are queued when a group is issued and
// popped by per-instance monitors on each output handshake.
// Honours TA_ROUND_COMP_EN for the expected values that depend on it.
// ----------------------------------------------------------------------------
module tb_ta_stream_accum;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] sum;
      logic        ovf;
      string       name;
   } exp_t;

   exp_t q16[$];
   exp_t q10[$];
   exp_t e16;
   exp_t e10;

   ta_stream_accum_if #(.BITWIDTH(8), .ACC_WIDTH(16), .MAX_BORDER(4), .LEN_WIDTH(8)) if16();
   ta_stream_accum_if #(.BITWIDTH(8), .ACC_WIDTH(10), .MAX_BORDER(4), .LEN_WIDTH(8)) if10();

   ta_stream_accum #(.BITWIDTH(8), .ACC_WIDTH(16), .MAX_BORDER(4), .LEN_WIDTH(8), .SUBTYPE(1))
      u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
   ta_stream_accum #(.BITWIDTH(8), .ACC_WIDTH(10), .MAX_BORDER(4), .LEN_WIDTH(8), .SUBTYPE(0))
      u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", n, act, exp);
      end
   endtask

   // monitors: a result is consumed on the edge following a negedge with valid && ready
   always @(negedge clk) begin
      if (rst_n && if16.out_valid && if16.out_ready) begin
         if (q16.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut16_unexpected: got sum %h, required no output", if16.out_sum);
         end else begin
            e16 = q16.pop_front();
            chk({e16.name, "_16"}, {15'd0, if16.out_ovf, if16.out_sum}, {15'd0, e16.ovf, e16.sum});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if10.out_valid && if10.out_ready) begin
         if (q10.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut10_unexpected: got sum %h, required no output", if10.out_sum);
         end else begin
            e10 = q10.pop_front();
            chk({e10.name, "_10"}, {15'd0, if10.out_ovf, 6'd0, if10.out_sum}, {15'd0, e10.ovf, e10.sum});
         end
      end
   end

   task automatic push16(input logic [15:0] s, input logic o, input string n);
      exp_t e;
      e.sum = s; e.ovf = o; e.name = n;
      q16.push_back(e);
   endtask

   task automatic push10(input logic [15:0] s, input logic o, input string n);
      exp_t e;
      e.sum = s; e.ovf = o; e.name = n;
      q10.push_back(e);
   endtask

   // one beat; called and returns at posedge+1
   task automatic send16(input logic [2:0] b, input logic [7:0] l, input logic [7:0] a);
      int n = 0;
      if16.cfg_border = b; if16.cfg_len = l; if16.in_a = a; if16.in_valid = 1'b1;
      @(negedge clk);
      while (!if16.in_ready && n < 50) begin @(negedge clk); n++; end
      if (!if16.in_ready) begin
         checks++; errors++;
         $display("FAIL send16_timeout: in_ready got 0 required 1");
      end
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
   endtask

   task automatic send10(input logic [2:0] b, input logic [7:0] l, input logic [7:0] a);
      int n = 0;
      if10.cfg_border = b; if10.cfg_len = l; if10.in_a = a; if10.in_valid = 1'b1;
      @(negedge clk);
      while (!if10.in_ready && n < 50) begin @(negedge clk); n++; end
      if (!if10.in_ready) begin
         checks++; errors++;
         $display("FAIL send10_timeout: in_ready got 0 required 1");
      end
      @(posedge clk); #1;
      if10.in_valid = 1'b0;
   endtask

   task automatic drain(input string n);
      int k = 0;
      while ((q16.size() != 0 || q10.size() != 0) && k < 100) begin @(posedge clk); k++; end
      checks++;
      if (q16.size() != 0 || q10.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: pending %0d/%0d results, required 0/0", n, q16.size(), q10.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      if16.in_valid = 0; if16.out_ready = 1; if16.cfg_border = 0; if16.cfg_len = 0; if16.in_a = 0;
      if10.in_valid = 0; if10.out_ready = 1; if10.cfg_border = 0; if10.cfg_len = 0; if10.in_a = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(if16.out_valid), 32'd0);
      chk("rst_out_sum",   32'(if16.out_sum),   32'd0);
      chk("rst_out_ovf",   32'(if16.out_ovf),   32'd0);
      chk("rst_in_ready",  32'(if16.in_ready),  32'd1);
      chk("rst_out_valid10", 32'(if10.out_valid), 32'd0);
      @(posedge clk); #1;

      // 1: border 2, three beats of 0x07
`ifdef TA_ROUND_COMP_EN
      push16(16'h0018, 1'b0, "t1_trunc");
`else
      push16(16'h000C, 1'b0, "t1_trunc");
`endif
      repeat (3) send16(3'd2, 8'd3, 8'h07);
      drain("t1");

      // 2: exact sum and one-cycle result latency
      push16(16'h0105, 1'b0, "t2_exact");
      send16(3'd0, 8'd4, 8'h01);
      send16(3'd0, 8'd4, 8'h02);
      send16(3'd0, 8'd4, 8'h03);
      chk("t2_valid_before_last", 32'(if16.out_valid), 32'd0);
      send16(3'd0, 8'd4, 8'hFF);
      chk("t2_valid_after_last", 32'(if16.out_valid), 32'd1);
      drain("t2");

      // 3: 10-bit accumulator saturates on beat 5
      push10(16'h03FF, 1'b1, "t3_sat");
      repeat (8) send10(3'd0, 8'd8, 8'hFF);
      drain("t3");

      // 4: back-pressure in HOLD, then zero-bubble handover
      if16.out_ready = 1'b0;
      push16(16'h0008, 1'b0, "t4_held");
      send16(3'd0, 8'd2, 8'h05);
      send16(3'd0, 8'd2, 8'h03);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_stall_valid", 32'(if16.out_valid), 32'd1);
         chk("t4_stall_sum",   32'(if16.out_sum),   32'h0008);
         chk("t4_stall_ready", 32'(if16.in_ready),  32'd0);
      end
      @(posedge clk); #1;
      push16(16'h0022, 1'b0, "t4_next");
      if16.out_ready = 1'b1;
      send16(3'd0, 8'd1, 8'h22);
      chk("t4_bubble_valid", 32'(if16.out_valid), 32'd1);
      chk("t4_bubble_sum",   32'(if16.out_sum),   32'h0022);
      drain("t4");

      // 5: len 0 acts as 1; border 7 clamps to 4 (0x37 -> 0x30, b=7 would give 0)
      push16(16'h0080, 1'b0, "t5_len0");
      send16(3'd0, 8'd0, 8'h80);
      push16(16'h0030, 1'b0, "t5_clamp");
      send16(3'd7, 8'd1, 8'h37);
      drain("t5");

      // 7: config changes after the first beat are ignored
`ifdef TA_ROUND_COMP_EN
      push16(16'h0020, 1'b0, "t7_cfg_latch");
`else
      push16(16'h0010, 1'b0, "t7_cfg_latch");
`endif
      send16(3'd3, 8'd2, 8'h0F);
      send16(3'd0, 8'd1, 8'h0C);
      drain("t7");

      // 6: reset mid-group discards the partial sum
      send16(3'd0, 8'd4, 8'h11);
      send16(3'd0, 8'd4, 8'h22);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid", 32'(if16.out_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_idle_valid", 32'(if16.out_valid), 32'd0);
      end
      @(posedge clk); #1;
      push16(16'h0010, 1'b0, "t6_after_rst");
      send16(3'd0, 8'd1, 8'h10);
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
